// File: rtl/bemf_avg_if.sv
// Read port of the shared back-EMF/current sample RAM.
// The averager drives the address and strobe; the RAM returns data one cycle later.
interface bemf_avg_if;
  logic [7:0]  RamAddr;
  logic        RamRd;
  logic [15:0] RamDataRd;

  modport master (output RamAddr, output RamRd, input RamDataRd);
  modport slave  (input RamAddr, input RamRd, output RamDataRd);
endinterface

// File: rtl/bemf_avg.sv
// Per-frame averager: reads the BEMF sample RAM after each frame and publishes
// the mean current and back-EMF sample of every axis.
//
// state | meaning
// IDLE  | waiting for an accepted Start
// ISSUE | one RAM address per cycle for the current group
// DRAIN | captures the sample of the last address
// DIV   | 19-cycle restoring divide of the group sum by N
// DONE  | publish all eight means, pulse Valid
module bemf_avg #(
  parameter int NUM_AXIS   = 4,
  parameter int SAMPLE_LSB = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Idle,
  input  logic [3:0]  CurrentReadings,
  input  logic [3:0]  BemfReadings,
  bemf_avg_if.master  ram,
  output logic [51:0] CurrentAvg,
  output logic [51:0] BemfAvg,
  output logic        Valid,
  output logic        Busy,
  output logic        Overrun,
  input  logic        OverrunClr
);
  localparam int NumGroups = 2 * NUM_AXIS;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DIV, DONE} stateT;
  stateT state, stateNext;

  logic [6:0]  nCur, nBemf, nGroup, sampleCnt;
  logic [2:0]  group;
  logic [7:0]  addr;
  logic [18:0] acc;
  logic [6:0]  rem, remNext;
  logic [7:0]  remShift;
  logic [4:0]  divCnt;
  logic [18:0] qNext;
  logic [12:0] quot, sample;
  logic [12:0] stage [NumGroups];
  logic        rdValid, qBit, lastIssue, divLast, groupLast, accept, abort;
  logic        unusedLsbs;

  assign accept     = (state == IDLE) && Start && Idle;
  assign abort      = (state != IDLE) && !Idle;
  assign nGroup     = group[2] ? nBemf : nCur;
  assign lastIssue  = sampleCnt == nGroup - 7'd1;
  assign divLast    = divCnt == 5'd18;
  assign groupLast  = group == 3'(NumGroups - 1);
  assign sample     = ram.RamDataRd[SAMPLE_LSB +: 13];
  assign unusedLsbs = ^ram.RamDataRd[SAMPLE_LSB-1:0];
  assign ram.RamAddr = addr;
  assign ram.RamRd   = (state == ISSUE);

  // acc holds the group sum, then shifts into the quotient during DIV
  always_comb begin
    remShift = {rem, acc[18]};
    qBit     = remShift >= {1'b0, nGroup};
    remNext  = qBit ? 7'(remShift - {1'b0, nGroup}) : remShift[6:0];
    qNext    = {acc[17:0], qBit};
    quot     = (|qNext[18:13]) ? 13'h1FFF : qNext[12:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = ISSUE;
      ISSUE:   if (lastIssue) stateNext = DRAIN;
      DRAIN:   stateNext = DIV;
      DIV:     if (divLast) stateNext = groupLast ? DONE : ISSUE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nCur       <= '0;
      nBemf      <= '0;
      sampleCnt  <= '0;
      group      <= '0;
      addr       <= '0;
      acc        <= '0;
      rem        <= '0;
      divCnt     <= '0;
      rdValid    <= 1'b0;
      CurrentAvg <= '0;
      BemfAvg    <= '0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      Overrun    <= 1'b0;
      for (int i = 0; i < NumGroups; i++) stage[i] <= '0;
    end else begin
      Valid   <= 1'b0;
      rdValid <= 1'b0;
      if (abort) begin
        Busy    <= 1'b0;
        Overrun <= 1'b1;
      end else begin
        if (OverrunClr) Overrun <= 1'b0;
        case (state)
          IDLE: if (accept) begin
            nCur      <= {1'b0, CurrentReadings, 2'b00} + 7'd4;
            nBemf     <= {1'b0, BemfReadings, 2'b00} + 7'd4;
            group     <= '0;
            addr      <= '0;
            sampleCnt <= '0;
            acc       <= '0;
            Busy      <= 1'b1;
          end
          ISSUE: begin
            rdValid <= 1'b1;
            if (!lastIssue) begin
              addr      <= addr + 8'd1;
              sampleCnt <= sampleCnt + 7'd1;
            end
          end
          DRAIN: begin
            rem    <= '0;
            divCnt <= '0;
          end
          DIV: begin
            acc    <= qNext;
            rem    <= remNext;
            divCnt <= divCnt + 5'd1;
            if (divLast) begin
              stage[group] <= quot;
              if (!groupLast) begin
                group     <= group + 3'd1;
                addr      <= addr + 8'd1;
                sampleCnt <= '0;
                acc       <= '0;
              end
            end
          end
          DONE: begin
            CurrentAvg <= {stage[3], stage[2], stage[1], stage[0]};
            BemfAvg    <= {stage[7], stage[6], stage[5], stage[4]};
            Valid      <= 1'b1;
            Busy       <= 1'b0;
          end
          default: ;
        endcase
        if (rdValid) acc <= acc + 19'(sample);
      end
    end
  end
endmodule

// File: tb/tb_bemf_avg.sv
// Directed bench for bemf_avg: RAM model, scoreboard of expected means, latency,
// abort, ignored-Start and reset-mid-pass checks.
module tb_bemf_avg;
  logic        Clk = 1'b0;
  logic        Reset, Start, Idle, OverrunClr;
  logic [3:0]  CurrentReadings, BemfReadings;
  logic [51:0] CurrentAvg, BemfAvg;
  logic        Valid, Busy, Overrun;

  logic [15:0]  mem [256];
  logic [103:0] expQ [$];
  logic [103:0] lastExp;
  logic [7:0]   addrLog [$];
  int total = 0;
  int bad = 0;
  int validCount = 0;

  bemf_avg_if ramIf ();

  bemf_avg #(.NUM_AXIS(4), .SAMPLE_LSB(3)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Idle(Idle),
    .CurrentReadings(CurrentReadings), .BemfReadings(BemfReadings),
    .ram(ramIf), .CurrentAvg(CurrentAvg), .BemfAvg(BemfAvg),
    .Valid(Valid), .Busy(Busy), .Overrun(Overrun), .OverrunClr(OverrunClr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (ramIf.RamRd) ramIf.RamDataRd <= mem[ramIf.RamAddr];

  always @(negedge Clk) begin
    if (Valid) validCount++;
    if (ramIf.RamRd) addrLog.push_back(ramIf.RamAddr);
  end

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fillConst(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic fillRand();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  function automatic logic [103:0] model(input int rc, input int rb);
    int nc, nb, n, addr, sum;
    logic [103:0] r;
    nc = 4 * (rc + 1);
    nb = 4 * (rb + 1);
    addr = 0;
    r = '0;
    for (int g = 0; g < 8; g++) begin
      n = (g < 4) ? nc : nb;
      sum = 0;
      for (int k = 0; k < n; k++) begin
        sum += int'(mem[addr % 256][15:3]);
        addr++;
      end
      r[g*13 +: 13] = 13'(sum / n);
    end
    return r;
  endfunction

  function automatic int expLat(input int rc, input int rb);
    return 4 * (4 * (rc + 1) + 20) + 4 * (4 * (rb + 1) + 20) + 2;
  endfunction

  task automatic checkIdleZero(input string tag);
    check({tag, "_cur"}, CurrentAvg, 0);
    check({tag, "_bemf"}, BemfAvg, 0);
    check({tag, "_valid"}, Valid, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_ovr"}, Overrun, 0);
    check({tag, "_rd"}, ramIf.RamRd, 0);
    check({tag, "_addr"}, ramIf.RamAddr, 0);
  endtask

  task automatic startPulse(input int rc, input int rb);
    CurrentReadings = 4'(rc);
    BemfReadings    = 4'(rb);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Full frame: scoreboard push at Start, pop and compare at Valid.
  task automatic runFrame(input int rc, input int rb, input bit midStart, input string tag);
    int lat, busyCnt, vc0, lim;
    logic [103:0] e;
    expQ.push_back(model(rc, rb));
    vc0 = validCount;
    lim = expLat(rc, rb) + 50;
    startPulse(rc, rb);
    CurrentReadings = ~CurrentReadings;
    BemfReadings    = ~BemfReadings;
    lat = 1;
    busyCnt = Busy ? 1 : 0;
    while (!Valid && lat < lim) begin
      tick();
      lat++;
      Start = midStart && (lat == 50);
      if (Busy) busyCnt++;
    end
    Start = 1'b0;
    check({tag, "_lat"}, lat, expLat(rc, rb));
    check({tag, "_busycyc"}, busyCnt, expLat(rc, rb) - 1);
    check({tag, "_busy_at_valid"}, Busy, 0);
    e = '0;
    if (expQ.size() != 0) e = expQ.pop_front();
    check({tag, "_cur"}, CurrentAvg, e[51:0]);
    check({tag, "_bemf"}, BemfAvg, e[103:52]);
    lastExp = e;
    tick();
    check({tag, "_pulse"}, Valid, 0);
    check({tag, "_nvalid"}, validCount - vc0, 1);
  endtask

  initial begin
    int n, vc0;
    Reset = 1'b1; Start = 1'b0; Idle = 1'b1; OverrunClr = 1'b0;
    CurrentReadings = '0; BemfReadings = '0; lastExp = '0;
    fillConst(16'h0808);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    checkIdleZero("reset");

    runFrame(0, 0, 1'b0, "fa");
    check("fa_257", {BemfAvg, CurrentAvg}, {8{13'd257}});

    fillRand();
    for (int k = 0; k < 8; k++) mem[8 + k] = 16'(k << 3);
    addrLog.delete();
    runFrame(1, 0, 1'b0, "fb");
    check("fb_ax1", CurrentAvg[25:13], 3);
    check("fb_nreads", addrLog.size(), 48);
    check("fb_cur_last", addrLog[31], 31);
    check("fb_bemf_base", addrLog[32], 32);

    fillRand();
    runFrame(2, 5, 1'b0, "fr");

    fillConst(16'hFFF8);
    addrLog.delete();
    runFrame(15, 15, 1'b0, "fc");
    check("fc_8191", {BemfAvg, CurrentAvg}, {8{13'h1FFF}});
    check("fc_nreads", addrLog.size(), 512);
    check("fc_wrap", addrLog[256], 0);
    check("fc_last", addrLog[511], 255);

    // Abort during bemf axis 2 issue
    fillRand();
    vc0 = validCount;
    startPulse(0, 0);
    n = 0;
    while (!(ramIf.RamRd && ramIf.RamAddr == 8'd24) && n < 500) begin
      tick();
      n++;
    end
    check("ab_reach", n < 500, 1);
    Idle = 1'b0;
    tick();
    Idle = 1'b1;
    check("ab_ovr", Overrun, 1);
    check("ab_busy", Busy, 0);
    check("ab_rd", ramIf.RamRd, 0);
    repeat (250) tick();
    check("ab_novalid", validCount - vc0, 0);
    check("ab_keep", {BemfAvg, CurrentAvg}, lastExp);
    OverrunClr = 1'b1;
    tick();
    OverrunClr = 1'b0;
    check("ab_clr", Overrun, 0);

    // Abort together with clear: set wins
    startPulse(0, 0);
    repeat (3) tick();
    Idle = 1'b0;
    OverrunClr = 1'b1;
    tick();
    Idle = 1'b1;
    OverrunClr = 1'b0;
    check("ab2_setwins", Overrun, 1);
    check("ab2_busy", Busy, 0);

    // Start while controller not idle is dropped
    Idle = 1'b0;
    startPulse(0, 0);
    Idle = 1'b1;
    repeat (3) tick();
    check("nidle_busy", Busy, 0);
    check("nidle_rd", ramIf.RamRd, 0);

    fillRand();
    runFrame(3, 1, 1'b1, "fm");

    // Reset during the first divide
    fillRand();
    startPulse(0, 0);
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkIdleZero("rst_div");
    lastExp = '0;
    runFrame(0, 0, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bemf_avg.md
Name: bemf_avg

Overview:
- Downstream consumer of the back-EMF/current sample RAM that the BEMF controller fills each measurement frame.
- On a frame-complete pulse, reads the frame's samples over the RAM's shared address/read port while the controller is idle.
- Computes the per-axis mean of current samples and of back-EMF samples, and publishes eight averaged values with a valid pulse for the velocity/servo loop.

Parameters:
- NUM_AXIS, 4, number of motor axes; the RAM layout is fixed for 4 (no other values supported).
- SAMPLE_LSB, 3, bit position of the 13-bit ADC sample inside each 16-bit RAM word (sample = word[15:3]).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle frame-complete pulse (rising edge of controller IntStatus).
- Idle  in  1  high while the controller is not writing RAM; reads are legal only while high.
- CurrentReadings  in  4  Rc; current samples per axis Nc = 4*(Rc+1).
- BemfReadings  in  4  Rb; back-EMF samples per axis Nb = 4*(Rb+1).
- RamAddr  out  8  RAM read address.
- RamRd  out  1  high while RamAddr must be muxed onto the RAM port.
- RamDataRd  in  16  RAM read data, valid 1 cycle after the address.
- CurrentAvg  out  52  four 13-bit means, axis0 in [12:0].
- BemfAvg  out  52  four 13-bit means, axis0 in [12:0].
- Valid  out  1  one-cycle pulse when all eight means have been updated.
- Busy  out  1  high from accepted Start until DONE or abort.
- Overrun  out  1  sticky abort flag.
- OverrunClr  in  1  clears Overrun.

Behaviour:
- Reset: state IDLE; all outputs 0 (both average buses 0, Valid 0, Busy 0, Overrun 0, RamRd 0, RamAddr 0).
- RAM layout (8-bit address, wraps mod 256):
  - current axis a, sample k: a*Nc + k;
  - bemf axis a, sample k: 4*Nc + a*Nb + k.
- Rc/Rb are latched at accepted Start; they are ignored mid-pass.
- Start is accepted only in IDLE with Idle=1; otherwise it is dropped (no queueing).
- IDLE -> ISSUE on Start.
- ISSUE, one address per cycle, RamRd=1:
  - samples are accumulated one cycle after their address (pipelined);
  - the accumulator is 19 bits, cleared at the start of each axis/region group;
  - after the last address, one drain cycle captures the final sample -> DIV.
- DIV: restoring divide, sum(19 bits) / N(7 bits).
  - Exactly 19 cycles.
  - Quotient truncated toward zero, then saturated to 13 bits (saturation never triggers for legal data).
  - Result written to the corresponding slot of CurrentAvg/BemfAvg.
- Group order: current axis 0..3, then bemf axis 0..3; each group is followed by ISSUE of the next.
  - After bemf axis 3 -> DONE.
- DONE: Valid=1 for one cycle, Busy=0 -> IDLE.
  - Latency from Start to Valid = sum over the 8 groups of (N+1+19) cycles, plus 2.
- Average buses are double-buffered: all eight values are copied to the outputs only in DONE. Outputs never show a mixed frame.
- Abort: Idle=0 in any state other than IDLE while Busy=1:
  - -> IDLE next cycle, Overrun=1, Busy=0, RamRd=0, no Valid;
  - outputs keep the previous frame.
- Overrun: OverrunClr clears it.
  - A simultaneous abort and OverrunClr leaves Overrun=1 (set wins).
- Start while Busy is ignored; it does not restart the pass.
- Reset mid-pass: immediate return to IDLE; outputs cleared to 0.
- RamRd=0 in IDLE, DIV and DONE. RamAddr holds its last value when RamRd=0.

Test Plan:
- Rc=0, Rb=0, RAM filled with word 16'h0808 (sample 257) everywhere, Start -> after 8*(4+1+19)+2=194 cycles Valid pulses once; all 8 means = 257; Busy high exactly between.
- Rc=1 (Nc=8), current axis1 samples 0..7 at addrs 8..15 -> CurrentAvg[25:13] = 3 (28/8 truncated); bemf region reads begin at address 32.
- Rb=15, Rc=15 (Nb=Nc=64), all samples 8191 -> accumulator 524224 without overflow, all means 8191; addresses wrap past 255 modulo 256.
- Idle dropped during bemf axis 2 ISSUE -> Overrun=1, Busy=0, no Valid, averages equal to the prior frame; OverrunClr -> Overrun=0.
- Start pulsed while Busy, and Start with Idle=0 -> both ignored; single Valid per accepted frame.
- Reset asserted during DIV -> next cycle all outputs 0, state IDLE; a subsequent Start completes normally.
